instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Producer side of the decoder's 32-bit instr interface. Holds the fetch PC, issues
//   word reads to instruction memory, buffers in-order responses in a FIFO and presents
//   {instr, instr_pc, instr_fault} to the decoder with a valid/ready handshake.
//   Branch/jump resolution redirects the PC; stale in-flight words are discarded.
// PARAMETERS
//   RESET_PC    32'h0000_0000  fetch address after reset
//   FIFO_DEPTH  4              response buffer entries; power of 2, >=2
// PORTS
//   clk             in   1   single clock, rising edge
//   rst_n           in   1   reset, synchronous, active-low
//   imem_req_valid  out  1   read request valid
//   imem_req_ready  in   1   memory accepts request
//   imem_req_addr   out  32  word address, [1:0]==0
//   imem_resp_valid in   1   response valid; in order, >=1 cycle after accept, no backpressure
//   imem_resp_data  in   32  instruction word
//   imem_resp_err   in   1   access fault for this response
//   instr_valid     out  1   decoder-side word valid
//   instr_ready     in   1   decoder accepts word
//   instr           out  32  instruction word to decoder
//   instr_pc        out  32  address of instr
//   instr_fault     out  1   word came from an erroring access
//   redirect_valid  in   1   branch/jump taken, one-cycle pulse
//   redirect_pc     in   32  new fetch address; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//   Reset (rst_n==0 at clk edge): pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0,
//     state=FETCH; imem_req_valid=0, instr_valid=0, instr/instr_pc=0, instr_fault=0.
//     imem shares rst_n; no response arrives for a pre-reset request.
//   FSM: FETCH -> issue requests. HALTED -> no requests; entered when a faulting entry
//     is pushed into the FIFO; left only by redirect (-> FETCH). Reset -> FETCH.
//   Issue: imem_req_valid = FETCH && (outstanding + fifo_count) < FIFO_DEPTH.
//     On req fire: pc += 4 (32-bit wrap 0xFFFF_FFFC -> 0), outstanding++.
//     A PC FIFO (depth FIFO_DEPTH) tags each fired address for its response.
//   Response: outstanding--. If drop_cnt>0: discard, drop_cnt--. Else push
//     {data, tagged pc, err} into FIFO. Credit rule guarantees FIFO never overflows.
//   Output: instr* driven from FIFO head; instr_valid = !empty. Pop on valid&&ready.
//     Latency: resp_valid at cycle N -> instr_valid at N+1 (no bypass).
//     Streaming 1-cycle memory, ready=1, FIFO_DEPTH>=4: one instr per cycle steady state.
//   Redirect (highest priority, same edge):
//     pc = {redirect_pc[31:2],2'b0}; FIFO flushed except that a pop completing this cycle
//     is honoured; drop_cnt = outstanding + req_fire_this_cycle - resp_this_cycle
//     (a response arriving this cycle is discarded); state=FETCH.
//     imem_req_valid may be high in the redirect cycle; its address is stale and dropped.
//   Simultaneous push+pop on full FIFO legal; count unchanged.
//   instr_* stable while instr_valid && !instr_ready.
// TESTING
//   1 Reset 3 cycles, release, imem_req_ready=1 -> first imem_req_addr=0x0, then 0x4,
//     0x8; instr_valid=0 throughout reset.
//   2 1-cycle memory returning 0x0000_0013 everywhere, instr_ready=1 -> instr_pc 0,4,8,...
//     one per cycle after fill; no gaps or duplicates over 100 words.
//   3 instr_ready=0 for 10 cycles -> exactly 4 requests outstanding or buffered, then
//     requests stop; release -> words delivered in address order, none lost.
//   4 Two requests in flight, redirect_pc=0x0000_0103 -> next req addr 0x100, both stale
//     responses discarded, first delivered instr_pc=0x100.
//   5 imem_resp_err=1 for pc 0x8 -> instr_fault=1 with instr_pc=0x8, no new requests;
//     redirect to 0x40 -> fetch resumes at 0x40, instr_fault=0.
//   6 Redirect in same cycle as a response and an output pop -> popped word accepted,
//     response dropped, FIFO empty next cycle; pc=0xFFFF_FFFC wraps to 0x0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit_if
// Brief   : Instruction-memory and decoder-side bundle of the fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output instr_valid, instr, instr_pc, instr_fault,
        input  instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  instr_valid, instr, instr_pc, instr_fault,
        output instr_ready, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : Fetch PC, imem request issue, in-order response FIFO, decoder
//           valid/ready output with redirect flush of stale words.
// Revision: 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_pc;
    logic [c_CNT_W-1:0]   r_outstanding;
    logic [c_CNT_W-1:0]   r_drop_cnt;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_tag_wr;
    logic [c_PTR_W-1:0]   r_tag_rd;

    logic [31:0]          r_fifo_data [FIFO_DEPTH];
    logic [31:0]          r_fifo_pc   [FIFO_DEPTH];
    logic                 r_fifo_err  [FIFO_DEPTH];
    logic [31:0]          r_tag_pc    [FIFO_DEPTH];

    logic [c_CNT_W:0]     w_credit;
    logic                 w_req_valid;
    logic                 w_req_fire;
    logic                 w_resp;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_redirect;
    logic [31:0]          w_redirect_pc;
    logic                 w_unused;

    assign w_redirect    = bus.redirect_valid;
    assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
    assign w_unused      = &{1'b0, bus.redirect_pc[1:0]};

    // Requests in flight plus buffered words never exceed the FIFO, so every
    // response has a slot waiting for it and no backpressure is needed.
    assign w_credit   = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_fire = w_req_valid && bus.imem_req_ready;
    assign w_resp     = bus.imem_resp_valid;
    assign w_drop     = (r_drop_cnt != '0);
    assign w_push     = w_resp && !w_drop && !w_redirect;
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && bus.instr_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        if (rst_n && (r_state == ST_FETCH) && (w_credit < c_DEPTH)) begin
            w_req_valid = 1'b1;
        end
        if (w_redirect) begin
            w_state_nxt = ST_FETCH;
        end else if (w_push && bus.imem_resp_err) begin
            w_state_nxt = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(w_resp);
            if (w_req_fire) begin
                r_tag_wr <= r_tag_wr + c_PTR_W'(1);
            end
            if (w_resp) begin
                r_tag_rd <= r_tag_rd + c_PTR_W'(1);
            end

            if (w_redirect) begin
                // Everything still in flight, including this cycle's request,
                // belongs to the abandoned path.
                r_pc       <= w_redirect_pc;
                r_drop_cnt <= r_outstanding + c_CNT_W'(w_req_fire) - c_CNT_W'(w_resp);
                r_count    <= '0;
                r_rd_ptr   <= r_wr_ptr;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_resp && w_drop) begin
                    r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_tag_pc[r_tag_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.imem_resp_data;
            r_fifo_pc[r_wr_ptr]   <= r_tag_pc[r_tag_rd];
            r_fifo_err[r_wr_ptr]  <= bus.imem_resp_err;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = !w_empty;
    assign bus.instr          = w_empty ? 32'h0 : r_fifo_data[r_rd_ptr];
    assign bus.instr_pc       = w_empty ? 32'h0 : r_fifo_pc[r_rd_ptr];
    assign bus.instr_fault    = w_empty ? 1'b0  : r_fifo_err[r_rd_ptr];
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Bench for instr_fetch_unit with an in-order memory model and
//           an epoch-tagged expected-word queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; logic err; int epoch; } exp_t;
    typedef struct { logic [31:0] addr; int fire_cyc; int epoch; } req_t;
    typedef struct { logic [31:0] rpc; int lat; logic [31:0] first_pc; logic [31:0] second_pc; } vec_t;

    exp_t        exp_q[$];
    req_t        mem_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] req_log[$];
    int          cyc = 0;
    int          epoch = 0;
    int          mem_lat = 1;
    int          fire_cnt = 0;
    int          pop_cnt = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] req_exp = 32'h0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h8;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 ^ {a[23:0], 8'h00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input string name);
        int k = 0;
        while (pop_log.size() < n && k < 60) begin
            step();
            k++;
        end
        if (pop_log.size() < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: actual=%0d pops required=%0d", name, pop_log.size(), n);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and scoreboard, evaluated mid-cycle
    always @(negedge clk) begin : mon
        req_t        r;
        exp_t        e;
        logic [31:0] d;
        logic        er;
        if (!rst_n) begin
            exp_q.delete();
            mem_q.delete();
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
            bus.imem_resp_err   = 1'b0;
            req_exp = 32'h0;
            epoch   = 0;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
            bus.imem_resp_err   = 1'b0;
            if (mem_q.size() > 0 && (mem_q[0].fire_cyc + mem_lat - 1) <= cyc) begin
                r  = mem_q.pop_front();
                d  = mem_word(r.addr);
                er = err_en && (r.addr == err_addr);
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = d;
                bus.imem_resp_err   = er;
                e.pc = r.addr; e.data = d; e.err = er; e.epoch = r.epoch;
                exp_q.push_back(e);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                while (exp_q.size() > 0 && exp_q[0].epoch < epoch) void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: actual pc=%h required=none", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", bus.instr_pc, e.pc);
                    check("out_instr", bus.instr, e.data);
                    check("out_fault", {31'b0, bus.instr_fault}, {31'b0, e.err});
                end
                pop_log.push_back(bus.instr_pc);
                pop_cnt++;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("req_addr", bus.imem_req_addr, req_exp);
                req_exp = req_exp + 32'd4;
                r.addr = bus.imem_req_addr; r.fire_cyc = cyc + 1; r.epoch = epoch;
                mem_q.push_back(r);
                req_log.push_back(bus.imem_req_addr);
                fire_cnt++;
            end
            if (bus.redirect_valid) begin
                epoch++;
                req_exp = {bus.redirect_pc[31:2], 2'b00};
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        vec_t vecs[4];
        int   valid_cnt;
        int   base;
        int   k;
        logic found;
        vecs[0] = '{32'h0000_0103, 3, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_1001, 1, 32'h0000_1000, 32'h0000_1004};
        vecs[2] = '{32'hFFFF_FFF8, 2, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        vecs[3] = '{32'h0000_2002, 3, 32'h0000_2000, 32'h0000_2004};

        rst_n = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset
        repeat (3) begin
            step();
            check("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
            check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        end
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 32'h0);
        check("rst_instr_fault", {31'b0, bus.instr_fault}, 32'h0);
        rst_n = 1'b1;

        // Decoder stalled: credit limit caps outstanding+buffered at 4
        repeat (12) step();
        check("stall_credit", fire_cnt - pop_cnt, 4);
        check("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        check("stall_head_pc", bus.instr_pc, 32'h0);
        check("stall_req_count", req_log.size(), 4);
        if (req_log.size() >= 3) begin
            check("first_req_0", req_log[0], 32'h0);
            check("first_req_1", req_log[1], 32'h4);
            check("first_req_2", req_log[2], 32'h8);
        end

        // Streaming one word per cycle
        bus.instr_ready = 1'b1;
        repeat (4) step();
        valid_cnt = 0;
        base = pop_cnt;
        for (int i = 0; i < 100; i++) begin
            step();
            valid_cnt += int'(bus.instr_valid);
        end
        check("stream_no_gaps", valid_cnt, 100);
        check("stream_pops", pop_cnt - base, 100);

        // Redirect vectors
        for (int i = 0; i < 4; i++) begin
            mem_lat = vecs[i].lat;
            repeat (8) step();
            if (vecs[i].lat >= 3)
                check("inflight_before_redirect", {31'b0, mem_q.size() >= 2}, 32'h1);
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = vecs[i].rpc;
            step();
            bus.redirect_valid = 1'b0;
            pop_log.delete();
            req_log.delete();
            check("redirect_flush_empty", {31'b0, bus.instr_valid}, 32'h0);
            wait_pops(2, "redirect_wait");
            if (pop_log.size() >= 2) begin
                check("redirect_first_pc", pop_log[0], vecs[i].first_pc);
                check("redirect_second_pc", pop_log[1], vecs[i].second_pc);
            end
            if (req_log.size() >= 1)
                check("redirect_first_req", req_log[0], vecs[i].first_pc);
        end

        // Faulting fetch halts issue until redirected
        mem_lat  = 1;
        err_en   = 1'b1;
        err_addr = 32'h8;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        found = 1'b0;
        k = 0;
        while (!found && k < 40) begin
            step();
            k++;
            if (bus.instr_valid && bus.instr_fault) found = 1'b1;
        end
        check("fault_seen", {31'b0, found}, 32'h1);
        check("fault_pc", bus.instr_pc, 32'h8);
        base = fire_cnt;
        repeat (10) step();
        check("halted_no_req", fire_cnt - base, 0);
        check("halted_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        pop_log.delete();
        wait_pops(1, "resume_wait");
        if (pop_log.size() >= 1) check("resume_pc", pop_log[0], 32'h40);
        check("resume_fault", {31'b0, bus.instr_fault}, 32'h0);
        repeat (4) step();
        err_en = 1'b0;

        // Redirect coinciding with a response and a pop; PC wrap
        repeat (6) step();
        base = pop_cnt;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        pop_log.delete();
        check("coinc_pop_taken", pop_cnt - base, 1);
        check("coinc_resp_present", {31'b0, bus.imem_resp_valid}, 32'h1);
        check("coinc_empty_after", {31'b0, bus.instr_valid}, 32'h0);
        wait_pops(2, "wrap_wait");
        if (pop_log.size() >= 2) begin
            check("wrap_first_pc", pop_log[0], 32'hFFFF_FFFC);
            check("wrap_second_pc", pop_log[1], 32'h0000_0000);
        end
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
